// File: rtl/pixel_frame_pkg.sv
// Shared state encoding and sizing helpers for the pixel frame controller.
package pixel_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ERASE,
        ST_EXPOSE,
        ST_CONVERT,
        ST_READ_ROW,
        ST_OUTPUT
    } state_t;

    // A single-row array still needs a one-bit row index.
    function automatic int row_w(input int num_rows);
        int w;
        w = $clog2(num_rows);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/pixel_ramp_counter.sv
// Ramp generator for the conversion phase: counts up while enabled, clears
// synchronously, and flags the last code so the controller can leave CONVERT.
module pixel_ramp_counter #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              clr,
    output logic [DATA_W-1:0] count,
    output logic              tc
);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + DATA_W'(1);
        end
    end

    assign tc = (count == '1);

endmodule

// File: rtl/pixel_frame_ctrl.sv
// Frame sequencer for a NUM_ROWS x NUM_COLS pixel array: erase, expose, ramp
// convert, then row-by-row readout over a valid/ready stream.
module pixel_frame_ctrl
    import pixel_frame_pkg::*;
#(
    parameter int NUM_ROWS    = 2,
    parameter int NUM_COLS    = 2,
    parameter int DATA_W      = 8,
    parameter int ERASE_CYC   = 5,
    parameter int READ_SETTLE = 2,
    parameter int CNT_W       = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         continuous,
    input  logic [CNT_W-1:0]             expose_len,
    input  logic [NUM_COLS*DATA_W-1:0]   pix_bus,
    input  logic                         out_ready,
    output logic                         erase,
    output logic                         expose,
    output logic                         convert,
    output logic [DATA_W-1:0]            adc_code,
    output logic [NUM_ROWS-1:0]          read,
    output logic [NUM_COLS*DATA_W-1:0]   data_out,
    output logic                         data_valid,
    output logic [row_w(NUM_ROWS)-1:0]   row_idx,
    output logic                         frame_done,
    output logic                         busy
);

    localparam int ROW_W = row_w(NUM_ROWS);
    localparam logic [CNT_W-1:0] ERASE_LAST  = CNT_W'(ERASE_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(READ_SETTLE - 1);
    localparam logic [ROW_W-1:0] ROW_LAST    = ROW_W'(NUM_ROWS - 1);

    state_t             state;
    state_t             next_state;
    logic [CNT_W-1:0]   tcnt;
    logic [CNT_W-1:0]   tcnt_next;
    logic [CNT_W-1:0]   exp_len_q;
    logic [ROW_W-1:0]   row;
    logic [ROW_W-1:0]   row_next;
    logic               latch_len;
    logic               capture;
    logic               frame_done_d;
    logic               ramp_tc;

    // The ramp only runs inside CONVERT and is held at zero everywhere else.
    pixel_ramp_counter #(.DATA_W(DATA_W)) u_ramp (
        .clk   (clk),
        .reset (reset),
        .en    (state == ST_CONVERT),
        .clr   (next_state != ST_CONVERT),
        .count (adc_code),
        .tc    (ramp_tc)
    );

    always_comb begin
        next_state   = state;
        tcnt_next    = tcnt;
        row_next     = row;
        latch_len    = 1'b0;
        capture      = 1'b0;
        frame_done_d = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    next_state = ST_ERASE;
                    tcnt_next  = '0;
                    latch_len  = 1'b1;
                end
            end
            ST_ERASE: begin
                if (tcnt == ERASE_LAST) begin
                    next_state = ST_EXPOSE;
                    tcnt_next  = '0;
                end else begin
                    tcnt_next = tcnt + CNT_W'(1);
                end
            end
            ST_EXPOSE: begin
                if (tcnt == exp_len_q - CNT_W'(1)) begin
                    next_state = ST_CONVERT;
                    tcnt_next  = '0;
                end else begin
                    tcnt_next = tcnt + CNT_W'(1);
                end
            end
            ST_CONVERT: begin
                if (ramp_tc) begin
                    next_state = ST_READ_ROW;
                    row_next   = '0;
                    tcnt_next  = '0;
                end
            end
            ST_READ_ROW: begin
                if (tcnt == SETTLE_LAST) begin
                    next_state = ST_OUTPUT;
                    capture    = 1'b1;
                    tcnt_next  = '0;
                end else begin
                    tcnt_next = tcnt + CNT_W'(1);
                end
            end
            ST_OUTPUT: begin
                if (data_valid && out_ready) begin
                    if (row == ROW_LAST) begin
                        frame_done_d = 1'b1;
                        if (continuous) begin
                            next_state = ST_ERASE;
                            latch_len  = 1'b1;
                        end else begin
                            next_state = ST_IDLE;
                        end
                    end else begin
                        row_next   = row + ROW_W'(1);
                        next_state = ST_READ_ROW;
                    end
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            tcnt       <= '0;
            row        <= '0;
            exp_len_q  <= '0;
            erase      <= 1'b0;
            expose     <= 1'b0;
            convert    <= 1'b0;
            read       <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            row_idx    <= '0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= next_state;
            tcnt       <= tcnt_next;
            row        <= row_next;
            if (latch_len) begin
                exp_len_q <= (expose_len == '0) ? CNT_W'(1) : expose_len;
            end
            erase      <= (next_state == ST_ERASE);
            expose     <= (next_state == ST_EXPOSE);
            convert    <= (next_state == ST_CONVERT);
            read       <= (next_state == ST_READ_ROW) ? (NUM_ROWS'(1) << row_next) : '0;
            data_valid <= (next_state == ST_OUTPUT);
            frame_done <= frame_done_d;
            busy       <= (next_state != ST_IDLE);
            if (capture) begin
                data_out <= pix_bus;
                row_idx  <= row;
            end
        end
    end

endmodule

// File: doc/pixel_frame_ctrl.md
Name: pixel_frame_ctrl

Overview:
- Parametrised successor to the fixed-size pixel top-level state machine.
- Sequences a pixel array of NUM_ROWS x NUM_COLS pixels through erase, expose, ramp-convert and row-by-row readout.
- Generates the digital ramp code during conversion and streams captured rows out over a valid/ready handshake with backpressure.
- Supports single-shot and continuous frame modes, and a runtime-programmable exposure length.

Parameters:
- NUM_ROWS, 2: pixel rows; one READ line per row.
- NUM_COLS, 2: pixels per row on the shared readout bus.
- DATA_W, 8: ADC code width; conversion lasts 2**DATA_W cycles.
- ERASE_CYC, 5: cycles ERASE is held high.
- READ_SETTLE, 2: cycles READ[r] is held before the bus is captured (minimum 1).
- CNT_W, 16: width of EXPOSE_LEN and the internal timing counter.

Ports:
- CLK, in, 1: single clock, rising edge.
- RESET, in, 1: synchronous, active-high reset.
- START, in, 1: level; begins a frame when sampled high in IDLE.
- CONTINUOUS, in, 1: sampled at end of frame; 1 restarts immediately.
- EXPOSE_LEN, in, CNT_W: exposure cycles; latched on each entry to ERASE; 0 is treated as 1.
- PIX_BUS, in, NUM_COLS*DATA_W: row data driven by the array while READ[r] is high.
- OUT_READY, in, 1: downstream ready.
- ERASE, out, 1: pixel erase.
- EXPOSE, out, 1: pixel expose.
- CONVERT, out, 1: conversion active.
- ADC_CODE, out, DATA_W: ramp code.
- READ, out, NUM_ROWS: one-hot row select.
- DATA_OUT, out, NUM_COLS*DATA_W: captured row.
- DATA_VALID, out, 1: DATA_OUT is valid.
- ROW_IDX, out, $clog2(NUM_ROWS) (minimum 1): row index of DATA_OUT.
- FRAME_DONE, out, 1: one-cycle pulse.
- BUSY, out, 1: high in any state other than IDLE.

Behaviour:
- All outputs are registered.
- Reset: on RESET the next state is IDLE, and every output, the row counter and the timing counter are 0. Reset applies from any state, including mid-conversion or while DATA_VALID is pending.
- States: IDLE, ERASE, EXPOSE, CONVERT, READ_ROW, OUTPUT.
- IDLE:
  - All control outputs are 0.
  - START=1 moves to ERASE on the next edge and latches EXPOSE_LEN.
  - START is ignored in all other states.
- ERASE: ERASE=1 for exactly ERASE_CYC cycles, then EXPOSE.
- EXPOSE: EXPOSE=1 for exactly max(latched EXPOSE_LEN, 1) cycles, then CONVERT.
- CONVERT:
  - CONVERT=1 for 2**DATA_W cycles.
  - ADC_CODE is 0 in the first CONVERT cycle and increments by 1 each cycle up to 2**DATA_W-1.
  - ADC_CODE never wraps and is 0 outside CONVERT.
  - Then go to READ_ROW with row=0.
- READ_ROW:
  - READ has bit row set for READ_SETTLE cycles.
  - On the last settle cycle, PIX_BUS is captured into DATA_OUT and ROW_IDX=row.
  - Next state is OUTPUT.
- OUTPUT:
  - READ=0 and DATA_VALID=1.
  - DATA_OUT and ROW_IDX stay stable while DATA_VALID=1 and OUT_READY=0 (no limit on the wait).
  - Handshake completes on DATA_VALID && OUT_READY at a clock edge; DATA_VALID drops on the next cycle.
  - If row < NUM_ROWS-1: row increments, go to READ_ROW.
  - Otherwise: FRAME_DONE=1 for the following single cycle. Next state is ERASE if CONTINUOUS=1 at that edge (EXPOSE_LEN relatched), else IDLE.
- Frame length with OUT_READY held at 1, from first ERASE cycle to FRAME_DONE:
  - ERASE_CYC + EXPOSE_LEN + 2**DATA_W + NUM_ROWS*(READ_SETTLE+1) cycles.
  - In continuous mode, FRAME_DONE coincides with the first ERASE cycle of the next frame.
- Exclusivity: ERASE, EXPOSE, CONVERT and any READ bit are mutually exclusive in every cycle. READ is at most one-hot.
- EXPOSE_LEN changes mid-frame have no effect until the next latch.

Decomposition:
- Package pixel_frame_pkg holds:
  - the state enum typedef;
  - a localparam function for ROW_IDX width, giving max($clog2(NUM_ROWS), 1).
- One natural sub-module, pixel_ramp_counter: a DATA_W-bit counter with enable, synchronous clear and terminal-count flag. It generates ADC_CODE and the CONVERT end condition.
- The FSM, timing counter and output register live in the top.

Test Plan:
- Single frame, defaults, EXPOSE_LEN=10, OUT_READY=1, START pulsed:
  - ERASE high for exactly 5 cycles, EXPOSE for 10, CONVERT for 256.
  - ADC_CODE steps 0..255.
  - READ=01 for 2 cycles, then READ=10 for 2 cycles.
  - Two DATA_VALID beats with ROW_IDX 0 then 1.
  - FRAME_DONE arrives 277 cycles after the first ERASE cycle; then IDLE with BUSY=0.
- Backpressure: PIX_BUS=16'hA55A during row 0, OUT_READY=0 for 20 cycles:
  - DATA_VALID stays high and DATA_OUT stays 16'hA55A for all 20 cycles.
  - READ=0 throughout.
  - Row 1 READ starts the cycle after OUT_READY rises.
- Continuous mode, CONTINUOUS=1, EXPOSE_LEN changed to 3 mid-frame:
  - The first frame still exposes for 10 cycles.
  - ERASE rises in the same cycle as FRAME_DONE.
  - The second frame exposes for 3 cycles.
- EXPOSE_LEN=0: EXPOSE is high for exactly 1 cycle.
- RESET asserted at CONVERT cycle 100 with ADC_CODE=99:
  - Next cycle all outputs are 0 and the state is IDLE.
  - A later START runs a full, correct frame.
- NUM_ROWS=4, NUM_COLS=3, DATA_W=4 build:
  - CONVERT lasts 16 cycles.
  - READ walks 0001, 0010, 0100, 1000.
  - Four beats with ROW_IDX 0..3, each DATA_OUT matching its row's 12-bit PIX_BUS pattern.
